// File: rtl/uart_tx_arbiter.sv
// Round-robin packet arbiter that shares one UART TX byte stream between NUM_CH requesters,
// with an optional channel-ID header byte and a forced release when a granted packet stalls.
module uart_tx_arbiter #(
    parameter int          NUM_CH      = 4,
    parameter int          DATA_WIDTH  = 8,
    parameter int          ADD_HEADER  = 1,
    parameter logic [3:0]  HDR_TAG     = 4'hA,
    parameter int          TIMEOUT_CYC = 65535
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_CH*DATA_WIDTH-1:0] i_req_data,
    input  logic [NUM_CH-1:0]            i_req_valid,
    input  logic [NUM_CH-1:0]            i_req_last,
    output logic [NUM_CH-1:0]            o_req_ready,
    output logic [DATA_WIDTH-1:0]        o_tx_data,
    output logic                         o_tx_valid,
    input  logic                         i_tx_ready,
    output logic [3:0]                   o_grant_id,
    output logic                         o_busy,
    output logic                         o_timeout
);

    localparam int GW = $clog2(NUM_CH);
    localparam int CW = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam logic [CW-1:0] CNT_LIMIT = (TIMEOUT_CYC > 0) ? CW'(TIMEOUT_CYC - 1) : '0;

    typedef enum logic [1:0] {IDLE, HDR, DATA} state_t;

    state_t                state, state_nxt;
    logic [GW-1:0]         gnt, last_gnt, arb_idx, cand;
    logic                  arb_found;
    logic [CW-1:0]         idle_cnt;
    logic [3:0]            grant_id_q, gnt4;
    logic                  cur_valid, cur_last, expire, up_beat;
    logic [DATA_WIDTH-1:0] cur_data;

    assign cur_valid = i_req_valid[gnt];
    assign cur_last  = i_req_last[gnt];
    assign cur_data  = i_req_data[gnt*DATA_WIDTH +: DATA_WIDTH];
    assign gnt4      = 4'(gnt);

    // Handshakes are suppressed on the expiry cycle so a late byte is not half-consumed during release.
    assign expire  = (TIMEOUT_CYC > 0) && (state == DATA) && (idle_cnt == CNT_LIMIT);
    assign up_beat = (state == DATA) && !expire && cur_valid && i_tx_ready;

    // Search starts one past the previous winner, so the last owner has lowest priority.
    always_comb begin
        // NOTE: every combinationally assigned signal gets a default first, otherwise a latch is inferred.
        arb_found = 1'b0;
        arb_idx   = '0;
        cand      = '0;
        for (int i = 1; i <= NUM_CH; i++) begin
            cand = GW'((int'(last_gnt) + i) % NUM_CH);
            if (!arb_found && i_req_valid[cand]) begin
                arb_found = 1'b1;
                arb_idx   = cand;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (arb_found) state_nxt = (ADD_HEADER != 0) ? HDR : DATA;
            HDR:  if (i_tx_ready) state_nxt = DATA;
            DATA: if (expire || (up_beat && cur_last)) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        o_req_ready = '0;
        o_tx_data   = '0;
        o_tx_valid  = 1'b0;
        o_busy      = (state != IDLE);
        o_timeout   = expire;
        case (state)
            HDR: begin
                o_tx_valid = 1'b1;
                o_tx_data  = DATA_WIDTH'({HDR_TAG, gnt4});
            end
            DATA: begin
                o_tx_data = cur_data;
                if (!expire) begin
                    o_tx_valid       = cur_valid;
                    o_req_ready[gnt] = i_tx_ready;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gnt        <= '0;
            last_gnt   <= GW'(NUM_CH - 1);
            grant_id_q <= '0;
            idle_cnt   <= '0;
        end else begin
            if (state == IDLE && arb_found) begin
                gnt        <= arb_idx;
                grant_id_q <= 4'(arb_idx);
            end
            if (expire || (up_beat && cur_last))
                last_gnt <= gnt;
            if (state != DATA || up_beat)
                idle_cnt <= '0;
            else if (!cur_valid && idle_cnt != '1)
                idle_cnt <= idle_cnt + CW'(1);
        end
    end

    assign o_grant_id = grant_id_q;

endmodule
